// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_flex buffer family.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for fifo_flex: one synchronous write port, one
// asynchronous read port.
module fifo_mem #(
  parameter int N    = 8,
  parameter int DEEP = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(DEEP)-1:0] waddr,
  input  logic [N-1:0]            wdata,
  input  logic [$clog2(DEEP)-1:0] raddr,
  output logic [N-1:0]            rdata
);

  logic [N-1:0] mem_q [DEEP];

  // NOTE: storage has no reset; contents are only meaningful between the
  // pointers, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read
// mode, programmable almost thresholds, occupancy count and sticky errors.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int         N     = 8,
  parameter int         DEEP  = 16,
  parameter fifo_mode_e MODE  = FIFO_STD,
  parameter int         AF_TH = DEEP - 2,
  parameter int         AE_TH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           in,
  input  logic                   wr,
  input  logic                   re,
  output logic [N-1:0]           out,
  output logic                   valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [cnt_w(DEEP)-1:0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int AW = $clog2(DEEP);
  localparam int CW = cnt_w(DEEP);

  if ((DEEP < 2) || ((DEEP & (DEEP - 1)) != 0)) begin : g_chk_deep
    $error("fifo_flex: DEEP must be a power of two >= 2");
  end
  if ((AF_TH < 1) || (AF_TH > DEEP)) begin : g_chk_af
    $error("fifo_flex: AF_TH must lie in 1..DEEP");
  end
  if ((AE_TH < 0) || (AE_TH > DEEP - 1)) begin : g_chk_ae
    $error("fifo_flex: AE_TH must lie in 0..DEEP-1");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, re_acc;
  logic [N-1:0]  rd_data;

  assign full         = (count_q == CW'(DEEP));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_TH));
  assign almost_empty = (count_q <= CW'(AE_TH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // Accept decisions use only registered state, so a read in the same
    // cycle never makes room for a write to a full FIFO.
    wr_acc   = wr & ~full;
    re_acc   = re & ~empty;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = re_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_acc && !re_acc) begin
      count_d = count_q + CW'(1);
    end else if (!wr_acc && re_acc) begin
      count_d = count_q - CW'(1);
    end
    overflow_d  = (overflow_q  & ~clr_err) | (wr & full);
    underflow_d = (underflow_q & ~clr_err) | (re & empty);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .N    (N),
    .DEEP (DEEP)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & rst_n),
    .waddr (wr_ptr_q),
    .wdata (in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [N-1:0] out_q, out_d;
    logic         valid_q, valid_d;

    always_comb begin
      out_d   = re_acc ? rd_data : out_q;
      valid_d = re_acc;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        out_q   <= out_d;
        valid_q <= valid_d;
      end
    end

    assign out   = out_q;
    assign valid = valid_q;
  end else begin : g_fwft
    // Head word is presented straight from storage; re pops it.
    assign out   = rd_data;
    assign valid = ~empty;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: one STD and one FWFT instance share the
// same stimulus and are checked against a queue-based reference model.
module tb_fifo_flex;
  import fifo_pkg::*;

  localparam int N    = 3;
  localparam int DEEP = 8;
  localparam int AF   = 6;
  localparam int AE   = 2;
  localparam int CW   = cnt_w(DEEP);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr = 1'b0, re = 1'b0, clr_err = 1'b0;
  logic [N-1:0] din = '0;

  logic [N-1:0]  s_out, f_out;
  logic          s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic          f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] s_count, f_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int model_q[$];
  int std_exp[$];
  bit m_ovf, m_unf, m_svalid;
  int m_slast;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  fifo_flex #(.N(N), .DEEP(DEEP), .MODE(FIFO_STD), .AF_TH(AF), .AE_TH(AE)) u_std (
    .clk(clk), .rst_n(rst_n), .in(din), .wr(wr), .re(re),
    .out(s_out), .valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
  );

  fifo_flex #(.N(N), .DEEP(DEEP), .MODE(FIFO_FWFT), .AF_TH(AF), .AE_TH(AE)) u_fwft (
    .clk(clk), .rst_n(rst_n), .in(din), .wr(wr), .re(re),
    .out(f_out), .valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents data.
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_valid === 1'b1) begin
        if (std_exp.size() == 0) check("std_unexpected_valid", 1, 0);
        else check("std_data", int'(s_out), std_exp.pop_front());
      end
      if (f_valid === 1'b1) begin
        if (model_q.size() == 0) check("fwft_unexpected_valid", 1, 0);
        else check("fwft_data", int'(f_out), model_q[0]);
      end
    end
  end

  task automatic check_status();
    int c;
    c = model_q.size();
    check("std_count", int'(s_count), c);
    check("std_full", int'(s_full), int'(c == DEEP));
    check("std_empty", int'(s_empty), int'(c == 0));
    check("std_af", int'(s_af), int'(c >= AF));
    check("std_ae", int'(s_ae), int'(c <= AE));
    check("std_ovf", int'(s_ovf), int'(m_ovf));
    check("std_unf", int'(s_unf), int'(m_unf));
    check("std_valid", int'(s_valid), int'(m_svalid));
    check("std_out_hold", int'(s_out), m_slast);
    check("fwft_count", int'(f_count), c);
    check("fwft_full", int'(f_full), int'(c == DEEP));
    check("fwft_empty", int'(f_empty), int'(c == 0));
    check("fwft_af", int'(f_af), int'(c >= AF));
    check("fwft_ae", int'(f_ae), int'(c <= AE));
    check("fwft_ovf", int'(f_ovf), int'(m_ovf));
    check("fwft_unf", int'(f_unf), int'(m_unf));
    check("fwft_valid", int'(f_valid), int'(c != 0));
  endtask

  // One clock: drive, update the model at the edge, check at the falling edge.
  task automatic cycle(input bit w, input bit r, input int d, input bit clr, input bit rst);
    bit full_now, empty_now, wa, ra;
    wr = w; re = r; din = N'(d); clr_err = clr; rst_n = !rst;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      std_exp.delete();
      m_ovf = 0; m_unf = 0; m_svalid = 0; m_slast = 0;
    end else begin
      full_now  = (model_q.size() == DEEP);
      empty_now = (model_q.size() == 0);
      wa = w && !full_now;
      ra = r && !empty_now;
      m_ovf = (m_ovf && !clr) || (w && full_now);
      m_unf = (m_unf && !clr) || (r && empty_now);
      m_svalid = ra;
      if (ra) begin
        m_slast = model_q.pop_front();
        std_exp.push_back(m_slast);
      end
      if (wa) model_q.push_back(d & ((1 << N) - 1));
    end
    @(negedge clk);
    wr = 0; re = 0; clr_err = 0; rst_n = 1;
    check_status();
  endtask

  initial begin
    int pw, pr;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    mon_en = 1'b1;
    check("reset_empty", int'(s_empty), 1);
    check("reset_out", int'(s_out), 0);

    // Fill in STD mode, then one write too many
    for (int i = 0; i < DEEP; i++) cycle(1, 0, i, 0, 0);
    check("fill_full", int'(s_full), 1);
    cycle(1, 0, 5, 0, 0);
    check("overflow_9th", int'(s_ovf), 1);
    check("count_stays_8", int'(s_count), 8);
    cycle(0, 0, 0, 1, 0);

    // Drain, then one read too many
    for (int i = 0; i < DEEP; i++) cycle(0, 1, 0, 0, 0);
    check("drain_last_out", int'(s_out), 7);
    cycle(0, 1, 0, 0, 0);
    check("underflow_9th", int'(s_unf), 1);
    check("underflow_no_valid", int'(s_valid), 0);
    cycle(0, 0, 0, 1, 0);

    // FWFT presentation and pop
    cycle(1, 0, 3, 0, 0);
    check("fwft_first_out", int'(f_out), 3);
    check("fwft_first_valid", int'(f_valid), 1);
    cycle(1, 0, 6, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("fwft_second_out", int'(f_out), 6);
    cycle(0, 1, 0, 0, 0);

    // Steady-state wrap at count 4
    for (int i = 0; i < 4; i++) cycle(1, 0, $urandom_range(0, 7), 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, $urandom_range(0, 7), 0, 0);
    check("wrap_count", int'(s_count), 4);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);

    // Edge cases
    cycle(1, 1, 5, 0, 0);
    check("wr_re_at_empty_count", int'(s_count), 1);
    check("wr_re_at_empty_unf", int'(s_unf), 1);
    for (int i = 0; i < 7; i++) cycle(1, 0, i + 1, 0, 0);
    cycle(1, 0, 1, 1, 0);
    check("clr_vs_set_ovf", int'(s_ovf), 1);
    cycle(0, 0, 0, 1, 0);
    check("clr_ovf", int'(s_ovf), 0);
    check("clr_unf", int'(s_unf), 0);

    // Reset mid-stream at count 5
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    check("pre_reset_count", int'(s_count), 5);
    cycle(0, 0, 0, 0, 1);
    check("rst_count", int'(s_count), 0);
    check("rst_ae", int'(s_ae), 1);
    check("rst_out", int'(s_out), 0);
    check("rst_fwft_valid", int'(f_valid), 0);
    cycle(1, 0, 2, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("post_reset_readback", int'(s_out), 2);

    // Randomized traffic with drifting bias to reach both full and empty
    for (int i = 0; i < 600; i++) begin
      pw = ((i / 100) % 2 == 0) ? 75 : 30;
      pr = 100 - pw;
      cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            $urandom_range(0, 7), $urandom_range(0, 99) < 5,
            $urandom_range(0, 199) == 0);
    end

    cycle(0, 0, 0, 0, 0);
    check("scoreboard_drained", std_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
